// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state encoding, forwarding source codes and the
// per-operand forwarding select used by the hazard controller.
package hazard_pkg;
   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } state_t;
   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;
   // EX is younger than MEM, so on a double match its value is the live one
   function automatic logic [1:0] fwd_sel(input logic [1:0] rs, input logic uses,
                                          input logic [1:0] ex_rd, input logic ex_we,
                                          input logic [1:0] mem_rd, input logic mem_we);
      return (uses && ex_we && rs == ex_rd) ? FWD_EXMEM :
             (uses && mem_we && rs == mem_rd) ? FWD_MEMWB : FWD_RF;
   endfunction
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational operand forwarding selects for both ID source registers.
module fwd_unit
   import hazard_pkg::*;
(
   input  logic [1:0] ID_RS_A,
   input  logic [1:0] ID_RS_B,
   input  logic       ID_USES_A,
   input  logic       ID_USES_B,
   input  logic [1:0] EX_RD_SEL,
   input  logic       EX_RF_WE,
   input  logic [1:0] MEM_RD_SEL,
   input  logic       MEM_RF_WE,
   output logic [1:0] FWD_A,
   output logic [1:0] FWD_B
);
   assign FWD_A = fwd_sel(ID_RS_A, ID_USES_A, EX_RD_SEL, EX_RF_WE, MEM_RD_SEL, MEM_RF_WE);
   assign FWD_B = fwd_sel(ID_RS_B, ID_USES_B, EX_RD_SEL, EX_RF_WE, MEM_RD_SEL, MEM_RF_WE);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush FSM with forwarding; optional saturating
// stall/flush performance counters enabled by macro HAZARD_PERF_CNT_EN.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  ID_RS_A,
   input  logic [1:0]  ID_RS_B,
   input  logic        ID_USES_A,
   input  logic        ID_USES_B,
   input  logic [1:0]  EX_RD_SEL,
   input  logic        EX_RF_WE,
   input  logic        EX_IS_LOAD,
   input  logic [1:0]  MEM_RD_SEL,
   input  logic        MEM_RF_WE,
   input  logic        EX_BRANCH_TAKEN,
   input  logic        EX_ret_enable,
   input  logic        MEM_DM_REQ,
   input  logic        DM_READY,
   output logic        PC_STALL,
   output logic        IF_ID_STALL,
   output logic        IF_ID_FLUSH,
   output logic        ID_EX_FLUSH,
   output logic        EX_MEM_STALL,
   output logic [1:0]  FWD_A,
   output logic [1:0]  FWD_B,
   output logic [1:0]  STATE,
   output logic [15:0] STALL_CNT,
   output logic [15:0] FLUSH_CNT
);
   state_t state, state_nxt;
   logic   load_use, pc_s, ifid_s, ifid_f, idex_f, exmem_s;

   fwd_unit u_fwd (
      .ID_RS_A(ID_RS_A), .ID_RS_B(ID_RS_B), .ID_USES_A(ID_USES_A), .ID_USES_B(ID_USES_B),
      .EX_RD_SEL(EX_RD_SEL), .EX_RF_WE(EX_RF_WE), .MEM_RD_SEL(MEM_RD_SEL),
      .MEM_RF_WE(MEM_RF_WE), .FWD_A(FWD_A), .FWD_B(FWD_B)
   );

   assign load_use = EX_IS_LOAD && EX_RF_WE &&
                     ((ID_USES_A && ID_RS_A == EX_RD_SEL) || (ID_USES_B && ID_RS_B == EX_RD_SEL));

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= RUN;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      pc_s = 1'b0;
      ifid_s = 1'b0;
      ifid_f = 1'b0;
      idex_f = 1'b0;
      exmem_s = 1'b0;
      case (state)
         RUN:
            if (MEM_DM_REQ && !DM_READY) begin
               {pc_s, ifid_s, exmem_s} = 3'b111;
               state_nxt = MEM_WAIT;
            end else if (EX_BRANCH_TAKEN || EX_ret_enable) begin
               {ifid_f, idex_f} = 2'b11;
               state_nxt = FLUSH;
            end else if (load_use) begin
               {pc_s, ifid_s, idex_f} = 3'b111;
               state_nxt = LOAD_STALL;
            end
         LOAD_STALL: state_nxt = RUN;
         FLUSH: begin
            ifid_f = 1'b1;
            state_nxt = RUN;
         end
         MEM_WAIT: begin
            {pc_s, ifid_s, exmem_s} = 3'b111;
            if (DM_READY) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   // Gate with rst so controls drop at once, not at the next edge
   assign PC_STALL     = pc_s && !rst;
   assign IF_ID_STALL  = ifid_s && !rst;
   assign IF_ID_FLUSH  = ifid_f && !rst;
   assign ID_EX_FLUSH  = idex_f && !rst;
   assign EX_MEM_STALL = exmem_s && !rst;
   assign STATE        = state;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         STALL_CNT <= '0;
         FLUSH_CNT <= '0;
      end else begin
         if (PC_STALL && STALL_CNT != 16'hFFFF) STALL_CNT <= STALL_CNT + 16'd1;
         if ((IF_ID_FLUSH || ID_EX_FLUSH) && FLUSH_CNT != 16'hFFFF) FLUSH_CNT <= FLUSH_CNT + 16'd1;
      end
`else
   assign STALL_CNT = '0;
   assign FLUSH_CNT = '0;
`endif
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The port list SHALL have one clock and an asynchronous active-high reset: clk  in  1  pipeline clock, all state on posedge; rst  in  1  asynchronous active-high reset.
REQ-002 The hazard-detection inputs SHALL be:
- ID_RS_A  in  2  source register A of the instruction in ID
- ID_RS_B  in  2  source register B of the instruction in ID
- ID_USES_A  in  1  ID reads RS_A
- ID_USES_B  in  1  ID reads RS_B
- EX_RD_SEL  in  2  EX destination register
- EX_RF_WE  in  1  EX writes the register file
- EX_IS_LOAD  in  1  EX is a data-memory load (RF_D_SEL selects memory)
- MEM_RD_SEL  in  2  MEM destination register
- MEM_RF_WE  in  1  MEM writes the register file
REQ-003 The control-flow and memory inputs SHALL be:
- EX_BRANCH_TAKEN  in  1  taken branch/jump resolved in EX
- EX_ret_enable  in  1  return resolved in EX
- MEM_DM_REQ  in  1  MEM stage accesses data memory
- DM_READY  in  1  data memory completes the access this cycle
REQ-004 The pipeline-control outputs SHALL be:
- PC_STALL  out  1  hold the PC
- IF_ID_STALL  out  1  hold IF/ID
- IF_ID_FLUSH  out  1  load a bubble into IF/ID
- ID_EX_FLUSH  out  1  load a bubble (all controls 0) into ID/EX
- EX_MEM_STALL  out  1  hold EX/MEM and ID/EX
REQ-005 The forwarding and status outputs SHALL be:
- FWD_A  out  2  operand A source: 0 register file, 1 EX/MEM, 2 MEM/WB
- FWD_B  out  2  operand B source, same encoding as FWD_A
- STATE  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 FLUSH, 3 MEM_WAIT
- STALL_CNT  out  16  performance counter, see REQ-020
- FLUSH_CNT  out  16  performance counter, see REQ-020

Function
REQ-006 FWD_A and FWD_B SHALL be combinational: 1 when the operand is used, EX_RF_WE=1 and EX_RD_SEL matches, else 2 when the operand is used, MEM_RF_WE=1 and MEM_RD_SEL matches, else 0; on a double match EX wins.
REQ-007 A load-use hazard SHALL be flagged when EX_IS_LOAD=1, EX_RF_WE=1 and EX_RD_SEL equals a used ID source.
REQ-008 RUN SHALL drive all stall/flush outputs 0 except in the cycles specified in REQ-009 to REQ-011.
REQ-009 MEM_WAIT condition: in RUN, MEM_DM_REQ=1 with DM_READY=0 SHALL assert PC_STALL, IF_ID_STALL and EX_MEM_STALL in that same cycle and move to MEM_WAIT.
REQ-010 Redirect condition: otherwise, EX_BRANCH_TAKEN=1 or EX_ret_enable=1 SHALL assert IF_ID_FLUSH and ID_EX_FLUSH in that same cycle and move to FLUSH.
REQ-011 Load-use condition: otherwise, a load-use hazard SHALL assert PC_STALL, IF_ID_STALL and ID_EX_FLUSH for exactly one cycle and move to LOAD_STALL.
REQ-012 Priority in RUN SHALL be MEM_WAIT > redirect > load-use; a redirect coincident with load-use flushes only.
REQ-013 LOAD_STALL SHALL drive no stall/flush and return to RUN after one cycle; forwarding then resolves the operand from MEM/WB (FWD=2).
REQ-014 FLUSH SHALL assert IF_ID_FLUSH for one further cycle, clearing the wrong-path instruction fetched during the redirect, then return to RUN.
REQ-015 MEM_WAIT SHALL hold PC_STALL, IF_ID_STALL and EX_MEM_STALL until DM_READY=1; the DM_READY=1 cycle keeps them asserted and the FSM returns to RUN on the next edge.
REQ-016 Redirect or load-use conditions arising during MEM_WAIT SHALL be ignored until RUN is re-entered, because the pipeline is frozen and they re-present.

Reset
REQ-017 rst=1 SHALL force STATE=RUN, STALL_CNT=0 and FLUSH_CNT=0 immediately.
REQ-018 rst=1 SHALL force all stall/flush outputs to 0 immediately, independent of clk.
REQ-019 Reset asserted during MEM_WAIT or FLUSH SHALL abandon the sequence without any residual stall.

Configuration
REQ-020 With macro HAZARD_PERF_CNT_EN defined, the counters SHALL be saturating 16-bit: STALL_CNT increments each cycle PC_STALL=1; FLUSH_CNT increments each cycle ID_EX_FLUSH or IF_ID_FLUSH=1; both hold at 0xFFFF.
REQ-021 With HAZARD_PERF_CNT_EN undefined, STALL_CNT and FLUSH_CNT SHALL be constant 0 and no counter flops exist.

Structure
REQ-022 A shared package hazard_pkg SHALL hold the state enum (RUN, LOAD_STALL, FLUSH, MEM_WAIT) and the FWD encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB).
REQ-023 The forwarding comparators SHALL be a sub-module fwd_unit, instantiated once with FWD_A and FWD_B as its outputs.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load to r1, then an ID instruction using r1 -> one cycle of PC_STALL/IF_ID_STALL/ID_EX_FLUSH, STATE=1, next cycle FWD_A=2.
- EX writes r2 and MEM writes r2, ID reads r2 on B -> FWD_B=1.
- EX_BRANCH_TAKEN pulse -> IF_ID_FLUSH for 2 cycles, ID_EX_FLUSH for 1, STATE 2 then 0.
- MEM_DM_REQ=1, DM_READY low for 3 cycles -> stalls for 4 cycles, STALL_CNT=4 with the macro defined, 0 without.
- rst asserted mid-MEM_WAIT between clock edges -> outputs 0 and STATE=0 before the next edge.
- Branch and load-use in the same cycle -> flush only, no PC_STALL.
